// File: rtl/umi_flex_pkg.sv
// Shared UMI command field layout, opcode constants and byte/length helpers
// used by the multi-channel flex mux.
package umi_flex_pkg;

  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_RESP_READ  = 5'h02;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;

  localparam int CMD_OPC_LSB  = 0;
  localparam int CMD_SIZE_LSB = 5;
  localparam int CMD_LEN_LSB  = 8;
  localparam int CMD_EOM_BIT  = 22;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } split_state_e;

  function automatic logic [31:0] cmd_bytes(input logic [2:0] size, input logic [7:0] len);
    return (32'(len) + 32'd1) << size;
  endfunction

  // len field for a chunk of nbytes bytes at the given element size
  function automatic logic [7:0] chunk_len(input logic [2:0] size, input logic [31:0] nbytes);
    return 8'((nbytes >> size) - 32'd1);
  endfunction

  function automatic logic is_splittable(input logic [4:0] opc);
    return (opc == UMI_REQ_WRITE) || (opc == UMI_REQ_POSTED) || (opc == UMI_RESP_READ);
  endfunction

endpackage

// File: rtl/umi_fifo_flex_mux_if.sv
// Bundle of the N input UMI streams and the single merged output stream.
interface umi_fifo_flex_mux_if #(
  parameter int N   = 4,
  parameter int IDW = 128,
  parameter int ODW = 32,
  parameter int CW  = 32,
  parameter int AW  = 64
);
  localparam int CHW = $clog2(N);

  logic [N-1:0]     umi_in_valid;
  logic [N-1:0]     umi_in_ready;
  logic [N*CW-1:0]  umi_in_cmd;
  logic [N*AW-1:0]  umi_in_dstaddr;
  logic [N*AW-1:0]  umi_in_srcaddr;
  logic [N*IDW-1:0] umi_in_data;

  logic             umi_out_valid;
  logic             umi_out_ready;
  logic [CW-1:0]    umi_out_cmd;
  logic [AW-1:0]    umi_out_dstaddr;
  logic [AW-1:0]    umi_out_srcaddr;
  logic [ODW-1:0]   umi_out_data;
  logic [CHW-1:0]   umi_out_chid;

  modport master (
    output umi_in_valid, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data,
    input  umi_in_ready,
    input  umi_out_valid, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data,
    input  umi_out_chid,
    output umi_out_ready
  );

  modport slave (
    input  umi_in_valid, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data,
    output umi_in_ready,
    output umi_out_valid, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data,
    output umi_out_chid,
    input  umi_out_ready
  );
endinterface

// File: rtl/umi_flex_chfifo.sv
// Per-channel FIFO with wrap-bit pointers; a written entry becomes visible to
// the reader one cycle after the write edge.
module umi_flex_chfifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_wr_valid,
  output logic         o_wr_ready,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_pop,
  output logic         o_rd_valid,
  output logic [W-1:0] o_rd_data
);
  localparam int PW   = $clog2(DEPTH);
  localparam int PTRW = PW + 1;

  logic [W-1:0]    r_mem [DEPTH];
  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW-1:0] r_wr_vis;
  logic [PTRW-1:0] r_rd_ptr;
  logic            w_full;
  logic            w_push;
  logic            w_pop;

  assign w_full     = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_wr_ready = ~w_full;
  assign o_rd_valid = (r_wr_vis != r_rd_ptr);
  assign w_push     = i_wr_valid & ~w_full;
  assign w_pop      = i_rd_pop & o_rd_valid;
  // Head is read combinationally so the splitter can load it in the pop cycle
  assign o_rd_data  = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_wr_vis <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTRW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTRW'(1);
      r_wr_vis <= r_wr_ptr;
    end
  end
endmodule

// File: rtl/umi_fifo_flex_mux.sv
// N-channel UMI merger: per-channel FIFOs, round-robin arbiter with message
// lock, and a splitter that cuts wide beats into ODW-sized chunks.
module umi_fifo_flex_mux
  import umi_flex_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDW   = 128,
  parameter int ODW   = 32,
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  umi_fifo_flex_mux_if.slave umi
);
  localparam int          CHW = $clog2(N);
  localparam int          EW  = CW + 2*AW + IDW;
  localparam logic [31:0] OB  = 32'(ODW / 8);

  logic [N-1:0]  w_fifo_valid;
  logic [N-1:0]  w_fifo_pop;
  logic [N-1:0]  w_in_ready;
  logic [EW-1:0] w_fifo_head [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      umi_flex_chfifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr_valid (umi.umi_in_valid[gi]),
        .o_wr_ready (w_in_ready[gi]),
        .i_wr_data  ({umi.umi_in_cmd[gi*CW +: CW], umi.umi_in_dstaddr[gi*AW +: AW],
                      umi.umi_in_srcaddr[gi*AW +: AW], umi.umi_in_data[gi*IDW +: IDW]}),
        .i_rd_pop   (w_fifo_pop[gi]),
        .o_rd_valid (w_fifo_valid[gi]),
        .o_rd_data  (w_fifo_head[gi])
      );
    end
  endgenerate

  assign umi.umi_in_ready = w_in_ready;

  split_state_e   r_state, w_state_next;
  logic           r_out_valid, w_valid_next;
  logic [CW-1:0]  r_out_cmd, w_cmd_next, r_in_cmd, w_in_cmd_next;
  logic [AW-1:0]  r_out_dst, w_dst_next, r_out_src, w_src_next;
  logic [ODW-1:0] r_out_data, w_data_next;
  logic [CHW-1:0] r_out_chid, w_chid_next;
  logic [31:0]    r_rem, w_rem_next;
  logic [IDW-1:0] r_rest, w_rest_next;
  logic [CHW-1:0] r_ptr, w_ptr_next, r_lock_ch, w_lock_ch_next;
  logic           r_locked, w_locked_next;

  logic           w_gnt_valid;
  logic [CHW-1:0] w_gnt;
  logic [CHW-1:0] w_cand;

  // Lowest non-empty channel at or after r_ptr, unless locked to a message
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = '0;
    w_cand      = '0;
    if (r_locked) begin
      w_gnt_valid = w_fifo_valid[r_lock_ch];
      w_gnt       = r_lock_ch;
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        w_cand = CHW'((int'(r_ptr) + k) % N);
        if (w_fifo_valid[w_cand]) begin
          w_gnt_valid = 1'b1;
          w_gnt       = w_cand;
        end
      end
    end
  end

  logic [EW-1:0]  w_head;
  logic [CW-1:0]  w_h_cmd;
  logic [AW-1:0]  w_h_dst, w_h_src;
  logic [IDW-1:0] w_h_data;
  logic [2:0]     w_h_size;
  logic [31:0]    w_h_bytes, w_chunk_b;
  logic           w_h_split, w_hs, w_last;

  assign w_head    = w_fifo_head[w_gnt];
  assign w_h_data  = w_head[IDW-1:0];
  assign w_h_src   = w_head[IDW +: AW];
  assign w_h_dst   = w_head[IDW+AW +: AW];
  assign w_h_cmd   = w_head[IDW+2*AW +: CW];
  assign w_h_size  = w_h_cmd[CMD_SIZE_LSB +: 3];
  assign w_h_bytes = cmd_bytes(w_h_size, w_h_cmd[CMD_LEN_LSB +: 8]);
  assign w_h_split = is_splittable(w_h_cmd[CMD_OPC_LSB +: 5]) && (w_h_bytes > OB)
                     && ((32'd1 << w_h_size) <= OB);
  assign w_chunk_b = (r_rem > OB) ? OB : r_rem;
  assign w_hs      = r_out_valid & umi.umi_out_ready;
  assign w_last    = (r_rem == 32'd0);

  always_comb begin
    w_state_next   = r_state;
    w_valid_next   = r_out_valid;
    w_cmd_next     = r_out_cmd;
    w_dst_next     = r_out_dst;
    w_src_next     = r_out_src;
    w_data_next    = r_out_data;
    w_chid_next    = r_out_chid;
    w_in_cmd_next  = r_in_cmd;
    w_rem_next     = r_rem;
    w_rest_next    = r_rest;
    w_ptr_next     = r_ptr;
    w_locked_next  = r_locked;
    w_lock_ch_next = r_lock_ch;
    w_fifo_pop     = '0;
    if (r_state == ST_SEND && w_hs && !w_last) begin
      w_cmd_next = r_in_cmd;
      w_cmd_next[CMD_LEN_LSB +: 8] = chunk_len(r_in_cmd[CMD_SIZE_LSB +: 3], w_chunk_b);
      w_cmd_next[CMD_EOM_BIT]      = r_in_cmd[CMD_EOM_BIT] && (r_rem == w_chunk_b);
      w_dst_next  = r_out_dst + AW'(OB);
      w_src_next  = r_out_src + AW'(OB);
      w_data_next = r_rest[ODW-1:0];
      w_rest_next = r_rest >> ODW;
      w_rem_next  = r_rem - w_chunk_b;
    end else if (r_state == ST_IDLE || w_hs) begin
      if (w_gnt_valid) begin
        w_fifo_pop[w_gnt] = 1'b1;
        w_state_next   = ST_SEND;
        w_valid_next   = 1'b1;
        w_cmd_next     = w_h_cmd;
        w_dst_next     = w_h_dst;
        w_src_next     = w_h_src;
        w_data_next    = w_h_data[ODW-1:0];
        w_chid_next    = w_gnt;
        w_in_cmd_next  = w_h_cmd;
        w_rem_next     = 32'd0;
        w_rest_next    = '0;
        w_ptr_next     = (w_gnt == CHW'(N - 1)) ? '0 : w_gnt + CHW'(1);
        w_locked_next  = ~w_h_cmd[CMD_EOM_BIT];
        w_lock_ch_next = w_gnt;
        if (w_h_split) begin
          w_cmd_next[CMD_LEN_LSB +: 8] = chunk_len(w_h_size, OB);
          w_cmd_next[CMD_EOM_BIT]      = 1'b0;
          w_rem_next  = w_h_bytes - OB;
          w_rest_next = w_h_data >> ODW;
        end
      end else begin
        w_state_next = ST_IDLE;
        w_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_cmd   <= '0;
      r_out_dst   <= '0;
      r_out_src   <= '0;
      r_out_data  <= '0;
      r_out_chid  <= '0;
      r_in_cmd    <= '0;
      r_rem       <= '0;
      r_rest      <= '0;
      r_ptr       <= '0;
      r_locked    <= 1'b0;
      r_lock_ch   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= w_valid_next;
      r_out_cmd   <= w_cmd_next;
      r_out_dst   <= w_dst_next;
      r_out_src   <= w_src_next;
      r_out_data  <= w_data_next;
      r_out_chid  <= w_chid_next;
      r_in_cmd    <= w_in_cmd_next;
      r_rem       <= w_rem_next;
      r_rest      <= w_rest_next;
      r_ptr       <= w_ptr_next;
      r_locked    <= w_locked_next;
      r_lock_ch   <= w_lock_ch_next;
    end
  end

  assign umi.umi_out_valid   = r_out_valid;
  assign umi.umi_out_cmd     = r_out_cmd;
  assign umi.umi_out_dstaddr = r_out_dst;
  assign umi.umi_out_srcaddr = r_out_src;
  assign umi.umi_out_data    = r_out_data;
  assign umi.umi_out_chid    = r_out_chid;
endmodule

// File: tb/tb_umi_fifo_flex_mux.sv
// Directed bench for the N-channel UMI flex mux: splitting, arbitration,
// message lock, backpressure and mid-split reset.
module tb_umi_fifo_flex_mux;
  import umi_flex_pkg::*;

  localparam int N = 4, IDW = 128, ODW = 32, CW = 32, AW = 64, DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  umi_fifo_flex_mux_if #(.N(N), .IDW(IDW), .ODW(ODW), .CW(CW), .AW(AW)) bus ();

  umi_fifo_flex_mux #(.N(N), .IDW(IDW), .ODW(ODW), .CW(CW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .umi   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_cmd(input logic [4:0] opc, input logic [2:0] size,
                                         input logic [7:0] len, input logic eom);
    return {9'd0, eom, 6'd0, len, size, opc};
  endfunction

  task automatic set_beat(input logic [1:0] ch, input logic [31:0] cmd,
                          input logic [63:0] dst, input logic [127:0] data);
    bus.umi_in_valid[ch]                = 1'b1;
    bus.umi_in_cmd[ch*CW +: CW]         = cmd;
    bus.umi_in_dstaddr[ch*AW +: AW]     = dst;
    bus.umi_in_srcaddr[ch*AW +: AW]     = dst + 64'h1000;
    bus.umi_in_data[ch*IDW +: IDW]      = data;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!bus.umi_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.umi_out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s: timeout, valid=%b required 1", name, bus.umi_out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.umi_in_valid = '0; bus.umi_in_cmd = '0; bus.umi_in_dstaddr = '0;
    bus.umi_in_srcaddr = '0; bus.umi_in_data = '0; bus.umi_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.umi_in_ready !== 4'hF) begin bad++; $display("FAIL rst_in_ready: got %h want f", bus.umi_in_ready); end
    total++; if (bus.umi_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.umi_out_valid); end
    total++; if (bus.umi_out_cmd !== 32'h0) begin bad++; $display("FAIL rst_cmd: got %h want 0", bus.umi_out_cmd); end
    total++; if (bus.umi_out_dstaddr !== 64'h0 || bus.umi_out_srcaddr !== 64'h0) begin bad++; $display("FAIL rst_addr: got %h/%h want 0/0", bus.umi_out_dstaddr, bus.umi_out_srcaddr); end
    total++; if (bus.umi_out_data !== 32'h0 || bus.umi_out_chid !== 2'd0) begin bad++; $display("FAIL rst_data_chid: got %h/%0d want 0/0", bus.umi_out_data, bus.umi_out_chid); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    logic [31:0] exp_data [4];
    exp_data = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    bus.umi_out_ready = 1'b1;
    set_beat(2'd0, mk_cmd(UMI_REQ_WRITE, 3'd0, 8'd15, 1'b1), 64'h100,
             128'h0F0E0D0C0B0A09080706050403020100);
    @(negedge clk);
    bus.umi_in_valid = '0;
    total++; if (bus.umi_out_valid !== 1'b0) begin bad++; $display("FAIL wr_lat_t: got %b want 0", bus.umi_out_valid); end
    @(negedge clk);
    total++; if (bus.umi_out_valid !== 1'b0) begin bad++; $display("FAIL wr_lat_t1: got %b want 0", bus.umi_out_valid); end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.umi_out_valid !== 1'b1) begin bad++; $display("FAIL wr_valid%0d: got %b want 1", k, bus.umi_out_valid); end
      total++; if (bus.umi_out_dstaddr !== 64'h100 + 64'(4*k)) begin bad++; $display("FAIL wr_dst%0d: got %h want %h", k, bus.umi_out_dstaddr, 64'h100 + 64'(4*k)); end
      total++; if (bus.umi_out_srcaddr !== 64'h1100 + 64'(4*k)) begin bad++; $display("FAIL wr_src%0d: got %h want %h", k, bus.umi_out_srcaddr, 64'h1100 + 64'(4*k)); end
      total++; if (bus.umi_out_cmd !== mk_cmd(UMI_REQ_WRITE, 3'd0, 8'd3, k == 3)) begin bad++; $display("FAIL wr_cmd%0d: got %h want %h", k, bus.umi_out_cmd, mk_cmd(UMI_REQ_WRITE, 3'd0, 8'd3, k == 3)); end
      total++; if (bus.umi_out_data !== exp_data[k] || bus.umi_out_chid !== 2'd0) begin bad++; $display("FAIL wr_data%0d: got %h/ch%0d want %h/ch0", k, bus.umi_out_data, bus.umi_out_chid, exp_data[k]); end
      @(negedge clk);
    end
    total++; if (bus.umi_out_valid !== 1'b0) begin bad++; $display("FAIL wr_end: got %b want 0", bus.umi_out_valid); end
  endtask

  task automatic test_read_ch2();
    set_beat(2'd2, mk_cmd(UMI_REQ_READ, 3'd0, 8'd15, 1'b1), 64'h200,
             128'hAAAABBBBCCCCDDDD0000111122334455);
    @(negedge clk);
    bus.umi_in_valid = '0;
    wait_out("rd_wait");
    total++; if (bus.umi_out_cmd !== mk_cmd(UMI_REQ_READ, 3'd0, 8'd15, 1'b1)) begin bad++; $display("FAIL rd_cmd: got %h want %h", bus.umi_out_cmd, mk_cmd(UMI_REQ_READ, 3'd0, 8'd15, 1'b1)); end
    total++; if (bus.umi_out_chid !== 2'd2) begin bad++; $display("FAIL rd_chid: got %0d want 2", bus.umi_out_chid); end
    total++; if (bus.umi_out_data !== 32'h22334455 || bus.umi_out_dstaddr !== 64'h200) begin bad++; $display("FAIL rd_data: got %h/%h want 22334455/200", bus.umi_out_data, bus.umi_out_dstaddr); end
    @(negedge clk);
    total++; if (bus.umi_out_valid !== 1'b0) begin bad++; $display("FAIL rd_single: got %b want 0", bus.umi_out_valid); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++)
        set_beat(2'(c), mk_cmd(UMI_REQ_READ, 3'd2, 8'd0, 1'b1), 64'h3000 + 64'(16*r + c), 128'(c));
      @(negedge clk);
      bus.umi_in_valid = '0;
      wait_out("rr_wait");
      for (int c = 0; c < 4; c++) begin
        total++; if (bus.umi_out_valid !== 1'b1 || bus.umi_out_chid !== 2'(c)) begin bad++; $display("FAIL rr_r%0d_b%0d: got valid=%b ch%0d want valid=1 ch%0d", r, c, bus.umi_out_valid, bus.umi_out_chid, c); end
        total++; if (bus.umi_out_dstaddr !== 64'h3000 + 64'(16*r + c)) begin bad++; $display("FAIL rr_dst_r%0d_b%0d: got %h want %h", r, c, bus.umi_out_dstaddr, 64'h3000 + 64'(16*r + c)); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_lock();
    logic [1:0]  exp_ch  [4];
    logic [63:0] exp_dst [4];
    exp_ch  = '{2'd0, 2'd1, 2'd1, 2'd3};
    exp_dst = '{64'h4000, 64'h4010, 64'h4011, 64'h4030};
    set_beat(2'd0, mk_cmd(UMI_REQ_READ, 3'd2, 8'd0, 1'b1), 64'h4000, 128'h0);
    set_beat(2'd1, mk_cmd(UMI_REQ_WRITE, 3'd2, 8'd0, 1'b0), 64'h4010, 128'h1);
    set_beat(2'd3, mk_cmd(UMI_REQ_READ, 3'd2, 8'd0, 1'b1), 64'h4030, 128'h3);
    @(negedge clk);
    bus.umi_in_valid = '0;
    set_beat(2'd1, mk_cmd(UMI_REQ_WRITE, 3'd2, 8'd0, 1'b1), 64'h4011, 128'h2);
    @(negedge clk);
    bus.umi_in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      wait_out("lock_wait");
      total++; if (bus.umi_out_chid !== exp_ch[i] || bus.umi_out_dstaddr !== exp_dst[i]) begin bad++; $display("FAIL lock_b%0d: got ch%0d/%h want ch%0d/%h", i, bus.umi_out_chid, bus.umi_out_dstaddr, exp_ch[i], exp_dst[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bus.umi_out_ready = 1'b0;
    set_beat(2'd1, mk_cmd(UMI_REQ_READ, 3'd2, 8'd0, 1'b1), 64'h5010, 128'h55AA55AA);
    @(negedge clk);
    bus.umi_in_valid = '0;
    wait_out("bp_hold_wait");
    for (int b = 0; b < 4; b++) begin
      total++; if (bus.umi_in_ready[0] !== 1'b1) begin bad++; $display("FAIL bp_ready_pre%0d: got %b want 1", b, bus.umi_in_ready[0]); end
      set_beat(2'd0, mk_cmd(UMI_REQ_READ, 3'd2, 8'd0, 1'b1), 64'h5000 + 64'(b), 128'hD0 + 128'(b));
      @(negedge clk);
    end
    bus.umi_in_valid = '0;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.umi_in_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_full%0d: got %b want 0", i, bus.umi_in_ready[0]); end
      total++; if (bus.umi_out_valid !== 1'b1 || bus.umi_out_data !== 32'h55AA55AA || bus.umi_out_chid !== 2'd1) begin bad++; $display("FAIL bp_stable%0d: got %b/%h/ch%0d want 1/55aa55aa/ch1", i, bus.umi_out_valid, bus.umi_out_data, bus.umi_out_chid); end
      @(negedge clk);
    end
    bus.umi_out_ready = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      wait_out("bp_drain_wait");
      total++; if (bus.umi_out_chid !== 2'd0 || bus.umi_out_data !== 32'hD0 + 32'(b) || bus.umi_out_dstaddr !== 64'h5000 + 64'(b)) begin bad++; $display("FAIL bp_drain%0d: got ch%0d/%h/%h want ch0/%h/%h", b, bus.umi_out_chid, bus.umi_out_data, bus.umi_out_dstaddr, 32'hD0 + 32'(b), 64'h5000 + 64'(b)); end
      @(negedge clk);
    end
    total++; if (bus.umi_out_valid !== 1'b0 || bus.umi_in_ready !== 4'hF) begin bad++; $display("FAIL bp_end: got valid=%b ready=%h want 0/f", bus.umi_out_valid, bus.umi_in_ready); end
  endtask

  task automatic test_reset_mid_split();
    int seen;
    bus.umi_out_ready = 1'b1;
    set_beat(2'd0, mk_cmd(UMI_REQ_POSTED, 3'd0, 8'd15, 1'b1), 64'h600,
             128'h33333333222222221111111100000000);
    @(negedge clk);
    bus.umi_in_valid = '0;
    wait_out("mid_wait");
    total++; if (bus.umi_out_dstaddr !== 64'h600) begin bad++; $display("FAIL mid_c1: got %h want 600", bus.umi_out_dstaddr); end
    @(negedge clk);
    total++; if (bus.umi_out_dstaddr !== 64'h604 || bus.umi_out_data !== 32'h11111111) begin bad++; $display("FAIL mid_c2: got %h/%h want 604/11111111", bus.umi_out_dstaddr, bus.umi_out_data); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.umi_out_valid !== 1'b0 || bus.umi_out_cmd !== 32'h0 || bus.umi_out_data !== 32'h0) begin bad++; $display("FAIL mid_rst: got %b/%h/%h want 0/0/0", bus.umi_out_valid, bus.umi_out_cmd, bus.umi_out_data); end
    reset = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.umi_out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_no_tail: got %0d beats want 0", seen); end
    total++; if (bus.umi_in_ready !== 4'hF) begin bad++; $display("FAIL mid_ready: got %h want f", bus.umi_in_ready); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_ch2();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_reset_mid_split();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
